// File: rtl/dec_enc_led_pkg.sv
// rtl/dec_enc_led_pkg.sv - shared constants and helpers for dec_enc_led
package dec_enc_led_pkg;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned VEC_W = 8;
  localparam int unsigned SEL_W = 3;

  localparam logic [CNT_W-1:0] DEFAULT_PERIOD = 32'd5000000;

  // Scanning upward lets the highest set bit overwrite lower ones.
  function automatic logic [SEL_W-1:0] prio_enc(input logic [VEC_W-1:0] x);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < VEC_W; i++) begin
      if (x[i]) begin
        idx = i[SEL_W-1:0];
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/dec_enc_led_if.sv
// rtl/dec_enc_led_if.sv - decoder/encoder signal bundle
interface dec_enc_led_if
  import dec_enc_led_pkg::*;
;

  logic [SEL_W-1:0] dec_x;
  logic             dec_en;
  logic [VEC_W-1:0] dec_y;
  logic [VEC_W-1:0] enc_x;
  logic             enc_en;
  logic [SEL_W-1:0] enc_y;
  logic             enc_valid;

  modport master (
    output dec_x, dec_en, enc_x, enc_en,
    input  dec_y, enc_y, enc_valid
  );

  modport slave (
    input  dec_x, dec_en, enc_x, enc_en,
    output dec_y, enc_y, enc_valid
  );

endinterface

// File: rtl/led_rotator.sv
// rtl/led_rotator.sv - period counter driving a rotating one-hot LED pattern
module led_rotator
  import dec_enc_led_pkg::*;
#(
  parameter logic [CNT_W-1:0] PERIOD = DEFAULT_PERIOD
) (
  input  logic             clk,
  input  logic             rst,
  output logic [VEC_W-1:0] pat
);

  localparam logic [CNT_W-1:0] LAST = PERIOD - 32'd1;

  logic [CNT_W-1:0] cnt;
  logic             step;

  assign step = (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (cnt >= LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat <= 8'h01;
    end else if (step) begin
      pat <= {pat[VEC_W-2:0], pat[VEC_W-1]};
    end
  end

endmodule

// File: rtl/dec_enc_led.sv
// rtl/dec_enc_led.sv - 3:8 decoder, 8:3 priority encoder and rotating LED bank
module dec_enc_led
  import dec_enc_led_pkg::*;
#(
  parameter logic [CNT_W-1:0] PERIOD = DEFAULT_PERIOD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [VEC_W-1:0]   sw,
  dec_enc_led_if.slave       bus,
  output logic [2*VEC_W-1:0] ledr
);

  logic [VEC_W-1:0] pat;

  led_rotator #(
    .PERIOD(PERIOD)
  ) u_rot (
    .clk(clk),
    .rst(rst),
    .pat(pat)
  );

  assign ledr = {pat, sw};

  // Decoder and encoder are pure combinational paths, untouched by reset.
  always_comb begin
    bus.dec_y = '0;
    if (bus.dec_en) begin
      bus.dec_y = 8'h01 << bus.dec_x;
    end
  end

  always_comb begin
    bus.enc_y     = '0;
    bus.enc_valid = bus.enc_en & (|bus.enc_x);
    if (bus.enc_en) begin
      bus.enc_y = prio_enc(bus.enc_x);
    end
  end

endmodule

// File: tb/tb_dec_enc_led.sv
// tb/tb_dec_enc_led.sv - scoreboard bench for dec_enc_led
module tb_dec_enc_led;

  typedef struct {
    int         kind;
    logic [7:0] exp;
    string      name;
  } item_t;

  logic        clk;
  logic        rst;
  logic [7:0]  sw;
  logic [15:0] ledr;
  logic [15:0] ledr1;

  dec_enc_led_if bus ();
  dec_enc_led_if bus1 ();

  dec_enc_led #(.PERIOD(32'd4)) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw),
    .bus (bus),
    .ledr(ledr)
  );

  dec_enc_led #(.PERIOD(32'd1)) dut1 (
    .clk (clk),
    .rst (rst),
    .sw  (sw),
    .bus (bus1),
    .ledr(ledr1)
  );

  item_t sb[$];
  event  sb_ev;
  int    checks   = 0;
  int    failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push(input int kind, input logic [7:0] exp, input string name);
    item_t it;
    it.kind = kind;
    it.exp  = exp;
    it.name = name;
    sb.push_back(it);
  endtask

  task automatic sample();
    -> sb_ev;
    #1;
  endtask

  function automatic logic [7:0] rot_n(input int n);
    logic [7:0] p;
    p = 8'h01;
    for (int k = 0; k < n % 8; k++) p = {p[6:0], p[7]};
    return p;
  endfunction

  initial begin
    item_t      it;
    logic [7:0] act;
    forever begin
      @(sb_ev);
      while (sb.size() > 0) begin
        it = sb.pop_front();
        case (it.kind)
          0:       act = bus.dec_y;
          1:       act = {5'd0, bus.enc_y};
          2:       act = {7'd0, bus.enc_valid};
          3:       act = ledr[15:8];
          4:       act = ledr[7:0];
          default: act = ledr1[15:8];
        endcase
        checks++;
        if (act !== it.exp) begin
          failures++;
          $display("FAIL %s: got %02h expected %02h at %0t", it.name, act, it.exp, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [7:0] dec_tab [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic       enc_en_tab [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [7:0] enc_x_tab  [6] = '{8'h00, 8'h01, 8'h96, 8'h2C, 8'hFF, 8'h40};
  logic [2:0] enc_y_tab  [6] = '{3'd0, 3'd0, 3'd7, 3'd5, 3'd0, 3'd6};
  logic       enc_v_tab  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    rst          = 1'b1;
    sw           = 8'hA5;
    bus.dec_x    = 3'd0;
    bus.dec_en   = 1'b0;
    bus.enc_x    = 8'h00;
    bus.enc_en   = 1'b0;
    bus1.dec_x   = 3'd0;
    bus1.dec_en  = 1'b0;
    bus1.enc_x   = 8'h00;
    bus1.enc_en  = 1'b0;
    #1 rst = 1'b0;
    #1;
    push(3, 8'h01, "reset_pat");
    push(5, 8'h01, "reset_pat_p1");
    push(4, 8'hA5, "sw_in_reset");
    sample();

    // Combinational paths exercised while reset is held.
    bus.dec_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.dec_x = i[2:0];
      #1;
      push(0, dec_tab[i], "dec_sweep");
      sample();
    end
    bus.dec_en = 1'b0;
    bus.dec_x  = 3'd5;
    #1;
    push(0, 8'h00, "dec_disabled");
    sample();

    for (int i = 0; i < 6; i++) begin
      bus.enc_en = enc_en_tab[i];
      bus.enc_x  = enc_x_tab[i];
      #1;
      push(1, {5'd0, enc_y_tab[i]}, "enc_y");
      push(2, {7'd0, enc_v_tab[i]}, "enc_valid");
      sample();
    end

    @(negedge clk);
    rst = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      @(posedge clk);
      #1;
      push(3, rot_n(e / 4), "rot_p4");
      push(5, rot_n(e), "rot_p1");
      sample();
    end

    sw = 8'h3C;
    #0;
    push(4, 8'h3C, "sw_live");
    sample();
    sw = 8'hA5;
    #0;
    push(4, 8'hA5, "sw_live2");
    sample();

    @(negedge clk);
    rst = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b1;
    for (int e = 1; e <= 13; e++) @(posedge clk);
    #1;
    push(3, 8'h08, "pre_midreset");
    sample();
    #1 rst = 1'b0;
    #1;
    push(3, 8'h01, "async_midreset");
    sample();

    @(negedge clk);
    rst = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1;
      push(3, (e < 4) ? 8'h01 : 8'h02, "post_midreset");
      sample();
    end

    #2;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d items left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dec_enc_led.md
DEC_ENC_LED -- requirements
Module: dec_enc_led

Interface
REQ-001 Parameter PERIOD, default 5000000, is the number of clk cycles between LED rotation steps; legal values are 1 to 2^32-1.
REQ-002 clk  input  1  is the single rising-edge clock for all sequential logic.
REQ-003 rst  input  1  is the asynchronous, active-low reset (0 = reset asserted).
REQ-004 sw  input  8  is the switch bank, passed through to ledr[7:0].
REQ-005 dec_x  input  3  is the decoder select code.
REQ-006 dec_en  input  1  is the decoder enable (1 = enabled).
REQ-007 enc_x  input  8  is the encoder request vector.
REQ-008 enc_en  input  1  is the encoder enable (1 = enabled).
REQ-009 ledr  output  16  carries the rotating LED pattern on [15:8] and a copy of sw on [7:0].
REQ-010 dec_y  output  8  is the one-hot decoder output.
REQ-011 enc_y  output  3  is the binary index from the priority encoder.
REQ-012 enc_valid  output  1  is 1 when the encoder is enabled and at least one request bit is set.

Function
REQ-013 Decoder (combinational): when dec_en=1, dec_y SHALL equal 1 shifted left by dec_x, giving exactly one bit set; when dec_en=0, dec_y SHALL be 8'h00.
REQ-014 Encoder (combinational):
- when enc_en=1, enc_y SHALL be the index of the highest set bit of enc_x (bit 7 has highest priority);
- when enc_en=0 or enc_x=8'h00, enc_y SHALL be 3'd0.
REQ-015 enc_valid SHALL equal enc_en AND (OR-reduction of enc_x); this is what distinguishes "bit 0 set" from "no request".
REQ-016 Decoder and encoder outputs SHALL have zero clock latency and SHALL ignore clk and rst.
REQ-017 LED counter:
- 32-bit counter cnt;
- each clk cycle, cnt SHALL go to 0 if cnt >= PERIOD-1, otherwise increment by 1;
- period is therefore exactly PERIOD cycles.
REQ-018 LED pattern:
- 8-bit register pat;
- on every clock edge where cnt == PERIOD-1, pat SHALL rotate left by one: pat <= {pat[6:0], pat[7]};
- bit 7 wraps to bit 0.
REQ-019 ledr SHALL equal {pat, sw}; ledr[7:0] is combinational from sw with no latency.
REQ-020 With PERIOD=1, pat SHALL rotate on every clock edge.

Reset
REQ-021 While rst=0, cnt SHALL be 0 and pat SHALL be 8'h01, immediately and without waiting for a clk edge; ledr[15:8] therefore reads 8'h01.
REQ-022 Asserting rst mid-count SHALL discard the partial count.
REQ-023 After rst is released, the first rotation SHALL occur on the PERIOD-th rising clk edge.
REQ-024 Reset SHALL NOT affect ledr[7:0], dec_y, enc_y or enc_valid.

Structure
REQ-025 The default PERIOD value and the counter width (32) SHALL be defined as constants in a shared package, dec_enc_led_pkg.
REQ-026 The LED rotator SHALL be a sub-module named led_rotator, holding cnt and pat.
REQ-027 The decoder and encoder SHALL be combinational logic in the top-level module, with no internal state.

Verification
REQ-028 Decoder sweep:
- dec_en=1, dec_x=0..7 -> dec_y = 01,02,04,08,10,20,40,80 (hex);
- dec_en=0, dec_x=5 -> dec_y = 00.
REQ-029 Encoder priority:
- enc_en=1, enc_x=8'h00 -> enc_y=0, enc_valid=0;
- enc_x=8'h01 -> enc_y=0, enc_valid=1;
- enc_x=8'h96 -> enc_y=7;
- enc_x=8'h2C -> enc_y=5;
- enc_en=0, enc_x=8'hFF -> enc_y=0, enc_valid=0.
REQ-030 LED rotation with PERIOD=4: after reset release, ledr[15:8] SHALL be 01 until the 4th rising edge, then 02, then 04 at edge 8, ..., reaching 80 at edge 28 and wrapping to 01 at edge 32.
REQ-031 Switch pass-through: sw=8'hA5 -> ledr[7:0]=8'hA5 in the same delta cycle, both during reset and outside it.
REQ-032 Asynchronous reset mid-operation (PERIOD=4):
- drive rst=0 between clock edges when pat=8'h08 -> ledr[15:8] SHALL become 01 before the next clk edge;
- after release, the next rotation SHALL occur on the 4th rising edge.
